// File: rtl/instruction_fetch.sv
// Instruction fetch stage: loadable instruction memory, PC, IF/ID register, IDLE/RUN/HALTED control.
// Optional macro IF_BRANCH_FLUSH_EN squashes the delay-slot word on a taken jump.
module instruction_fetch #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_MEM_ADDR = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(32'hFFFFFFFF)
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [NB_DATA-1:0]     i_addr2jump,
  input  logic                   i_inst_we,
  input  logic [NB_MEM_ADDR-1:0] i_inst_wr_addr,
  input  logic [NB_DATA-1:0]     i_inst_wr_data,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic [NB_DATA-1:0]     o_pc,
  output logic                   o_halt
);

  localparam int unsigned DEPTH = 1 << NB_MEM_ADDR;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t                 state;
  logic [NB_DATA-1:0]     mem [DEPTH];
  logic [NB_DATA-1:0]     pc;
  logic [NB_MEM_ADDR-1:0] fetch_idx;
  logic [NB_DATA-1:0]     fetch_word;
  logic [NB_DATA-1:0]     pc_plus4;
  logic [NB_DATA-1:0]     jump_target;
  logic                   is_halt;

  // Fetch index wraps with memory depth; pc itself spans the full width.
  assign fetch_idx   = pc[NB_MEM_ADDR+1:2];
  assign fetch_word  = mem[fetch_idx];
  assign pc_plus4    = pc + NB_DATA'(4);
  assign jump_target = i_addr2jump & ~NB_DATA'(3);
  assign is_halt     = (fetch_word == HALT_WORD);
  assign o_pc        = pc;

  // Loader port is only honoured while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && i_inst_we) begin
      mem[i_inst_wr_addr] <= i_inst_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= IDLE;
      pc            <= '0;
      o_instruction <= '0;
      o_pcounter4   <= '0;
      o_halt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_instruction <= '0;
          o_pcounter4   <= '0;
          o_halt        <= 1'b0;
          if (i_start) begin
            state <= RUN;
          end
        end
        RUN: begin
          // Stall wins over jump; decode re-issues the jump afterwards.
          if (!i_stall) begin
            pc            <= i_jump ? jump_target : pc_plus4;
            o_instruction <= fetch_word;
            o_pcounter4   <= pc_plus4;
`ifdef IF_BRANCH_FLUSH_EN
            if (i_jump && !is_halt) begin
              o_instruction <= '0;
              o_pcounter4   <= '0;
            end
`endif
            if (is_halt) begin
              state  <= HALTED;
              o_halt <= 1'b1;
            end
          end
        end
        HALTED: begin
          o_instruction <= '0;
          o_halt        <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch, including a 4-word instance for fetch-index wrap.
module tb_instruction_fetch;

  logic        clk;
  logic        rst, start, stall, jump, we;
  logic [31:0] addr2jump, wd;
  logic [7:0]  wa;
  logic [31:0] instr, pc4, pc;
  logic        halt;

  logic        s_rst, s_start, s_we;
  logic [1:0]  s_wa;
  logic [31:0] s_wd;
  logic [31:0] s_instr, s_pc4, s_pc;
  logic        s_halt;

  int n_assert;
  int n_fail;

`ifdef IF_BRANCH_FLUSH_EN
  localparam logic [31:0] EXP_DS_INSTR = 32'h0;
  localparam logic [31:0] EXP_DS_PC4   = 32'h0;
`else
  localparam logic [31:0] EXP_DS_INSTR = 32'h20020003;
  localparam logic [31:0] EXP_DS_PC4   = 32'h8;
`endif

  instruction_fetch dut (
    .clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_jump(jump),
    .i_addr2jump(addr2jump), .i_inst_we(we), .i_inst_wr_addr(wa), .i_inst_wr_data(wd),
    .o_instruction(instr), .o_pcounter4(pc4), .o_pc(pc), .o_halt(halt)
  );

  instruction_fetch #(.NB_MEM_ADDR(2)) dut_small (
    .clk(clk), .i_rst(s_rst), .i_start(s_start), .i_stall(1'b0), .i_jump(1'b0),
    .i_addr2jump(32'h0), .i_inst_we(s_we), .i_inst_wr_addr(s_wa), .i_inst_wr_data(s_wd),
    .o_instruction(s_instr), .o_pcounter4(s_pc4), .o_pc(s_pc), .o_halt(s_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; we = 1'b0;
    addr2jump = '0; wa = '0; wd = '0;
    s_rst = 1'b1; s_start = 1'b0; s_we = 1'b0; s_wa = '0; s_wd = '0;
    tick();
    rst = 1'b0; s_rst = 1'b0;
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);

    // Jump and stall are inert while idle
    jump = 1'b1; stall = 1'b1; addr2jump = 32'h43;
    tick();
    jump = 1'b0; stall = 1'b0;
    check("idle_jump_pc", pc, 32'h0);
    check("idle_instr", instr, 32'h0);

    load(8'd0, 32'h20010005);
    load(8'd1, 32'h20020003);
    load(8'd2, 32'hFFFFFFFF);
    load(8'd16, 32'h00000044);
    load(8'd17, 32'hFFFFFFFF);

    // Basic program to halt
    start = 1'b1; tick(); start = 1'b0;
    check("start_instr", instr, 32'h0);
    tick();
    check("a_instr0", instr, 32'h20010005);
    check("a_pc4_0", pc4, 32'h4);
    check("a_halt0", {31'b0, halt}, 32'h0);
    tick();
    check("a_instr1", instr, 32'h20020003);
    check("a_pc4_1", pc4, 32'h8);
    tick();
    check("a_instr2", instr, 32'hFFFFFFFF);
    check("a_pc4_2", pc4, 32'hC);
    check("a_halt2", {31'b0, halt}, 32'h1);
    tick();
    check("a_nop", instr, 32'h0);
    check("a_pc4_frz", pc4, 32'hC);
    check("a_pc_frz", pc, 32'hC);
    stall = 1'b1; jump = 1'b1;
    tick();
    stall = 1'b0; jump = 1'b0;
    check("halted_jump_pc", pc, 32'hC);
    check("halted_still", {31'b0, halt}, 32'h1);

    // Stall for three cycles at pc=8, jump ignored while stalled
    do_reset();
    check("rst2_halt", {31'b0, halt}, 32'h0);
    check("rst2_pc", pc, 32'h0);
    load(8'd2, 32'h00000022);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("b_pc8", pc, 32'h8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      jump = (k == 1); addr2jump = 32'h43;
      tick();
      check("b_stall_instr", instr, 32'h20020003);
      check("b_stall_pc4", pc4, 32'h8);
      check("b_stall_pc", pc, 32'h8);
    end
    stall = 1'b0; jump = 1'b0;
    tick();
    check("b_resume_instr", instr, 32'h00000022);
    check("b_resume_pc4", pc4, 32'hC);
    check("b_resume_pc", pc, 32'hC);

    // Reset mid-run
    do_reset();
    check("midrst_pc", pc, 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_pc4", pc4, 32'h0);

    // Jump at pc=4, with a loader write attempted during RUN
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("c_pc4", pc, 32'h4);
    jump = 1'b1; addr2jump = 32'h43; we = 1'b1; wa = 8'd0; wd = 32'hDEADBEEF;
    tick();
    jump = 1'b0; we = 1'b0;
    check("c_jump_pc", pc, 32'h40);
    check("c_ds_instr", instr, EXP_DS_INSTR);
    check("c_ds_pc4", pc4, EXP_DS_PC4);
    tick();
    check("c_tgt_instr", instr, 32'h00000044);
    check("c_tgt_pc4", pc4, 32'h44);
    tick();
    check("c_halt_instr", instr, 32'hFFFFFFFF);
    check("c_halt", {31'b0, halt}, 32'h1);
    tick();
    check("c_nop", instr, 32'h0);
    check("c_pc_frz", pc, 32'h48);

    // Memory preserved across reset and the RUN-time write was dropped
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("d_mem0", instr, 32'h20010005);

    // Write coinciding with start is visible to the first fetch
    do_reset();
    start = 1'b1; we = 1'b1; wa = 8'd0; wd = 32'h0000ABCD;
    tick();
    start = 1'b0; we = 1'b0;
    tick();
    check("e_wr_start", instr, 32'h0000ABCD);

    // Fetch index wraps on the 4-word instance
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_wa = 2'(i); s_wd = 32'hA0 + 32'(i);
      tick();
    end
    s_we = 1'b0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w_instr", s_instr, 32'hA0 + 32'(i));
      check("w_pc4", s_pc4, 32'(4 * (i + 1)));
    end
    check("w_pc16", s_pc, 32'h10);
    tick();
    check("w_wrap_instr", s_instr, 32'hA0);
    check("w_wrap_pc4", s_pc4, 32'h14);
    check("w_wrap_pc", s_pc, 32'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, instruction/PC width.
REQ-002 SHALL have parameter NB_MEM_ADDR, default 8, instruction-memory word-address width (256 words).
REQ-003 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program encoding.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_start  in  1  one-cycle pulse, begin execution after program load.
REQ-007 SHALL have port i_stall  in  1  hazard stall from the decode stage, holds the fetch stage.
REQ-008 SHALL have port i_jump  in  1  taken jump/branch resolved in decode.
REQ-009 SHALL have port i_addr2jump  in  NB_DATA  jump target byte address.
REQ-010 SHALL have port i_inst_we  in  1  loader write enable.
REQ-011 SHALL have port i_inst_wr_addr  in  NB_MEM_ADDR  loader word address.
REQ-012 SHALL have port i_inst_wr_data  in  NB_DATA  loader instruction word.
REQ-013 SHALL have port o_instruction  out  NB_DATA  registered IF/ID instruction.
REQ-014 SHALL have port o_pcounter4  out  NB_DATA  registered PC+4 of o_instruction.
REQ-015 SHALL have port o_pc  out  NB_DATA  current fetch PC (debug).
REQ-016 SHALL have port o_halt  out  1  high while the stage is in HALTED.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALTED; IDLE->RUN on i_start; RUN->HALTED when the fetched word equals HALT_WORD and i_stall=0; HALTED exits only via i_rst.
REQ-018 SHALL hold 2^NB_MEM_ADDR words internally with asynchronous read at pc[NB_MEM_ADDR+1:2] and synchronous write.
REQ-019 SHALL accept loader writes only in IDLE and ignore i_inst_we in RUN and HALTED.
REQ-020 SHALL, in RUN with i_stall=0, register o_instruction<=mem[pc], o_pcounter4<=pc+4, and update pc<=i_jump ? {i_addr2jump[NB_DATA-1:2],2'b00} : pc+4, for 1-cycle fetch latency.
REQ-021 SHALL give i_stall priority over i_jump: while stalled, pc, o_instruction and o_pcounter4 hold and i_jump is ignored; decode re-asserts the jump after the stall.
REQ-022 SHALL wrap the fetch index modulo 2^NB_MEM_ADDR when pc exceeds memory depth, while pc itself increments across the full NB_DATA width.
REQ-023 SHALL pass HALT_WORD to o_instruction exactly once, then drive o_instruction=0 (NOP) and freeze pc and o_pcounter4 in HALTED.
REQ-024 SHALL drive o_instruction=0 and o_pcounter4=0 in IDLE; i_stall and i_jump SHALL have no effect in IDLE or HALTED.
REQ-025 SHALL, when i_inst_we and i_start coincide in IDLE, perform the write, and the first RUN fetch SHALL see the written data.

Reset
REQ-026 SHALL, on i_rst=1 at a clock edge, set state=IDLE, pc=0, o_instruction=0, o_pcounter4=0, o_halt=0 from any state including mid-RUN.
REQ-027 SHALL leave instruction-memory contents unchanged across reset.

Configuration
REQ-028 SHALL support macro IF_BRANCH_FLUSH_EN. When it is defined, a taken, unstalled i_jump SHALL load o_instruction=0 (NOP) and o_pcounter4=0 instead of the sequential word, squashing it. When it is undefined, the sequential word is registered normally, giving MIPS branch-delay-slot semantics.

Verification
REQ-029 SHALL cover: load words 0x20010005, 0x20020003, 0xFFFFFFFF at addresses 0..2, then i_start -> o_instruction 0x20010005/0x20020003/0xFFFFFFFF on successive cycles, o_pcounter4 4/8/12, o_halt=1 after the third word, then o_instruction=0.
REQ-030 SHALL cover: i_stall=1 for 3 cycles in RUN at pc=8 -> o_instruction and o_pcounter4 constant, o_pc=8 throughout, fetch resumes at 8.
REQ-031 SHALL cover: i_jump=1, i_addr2jump=0x43 at pc=4 -> next pc=0x40; delay-slot word at 4 is registered without the macro and replaced by 0 with IF_BRANCH_FLUSH_EN.
REQ-032 SHALL cover: i_jump=1 together with i_stall=1 -> pc unchanged, jump ignored.
REQ-033 SHALL cover: i_inst_we=1 in RUN at addr 0 with data 0xDEADBEEF -> memory unchanged; i_rst mid-RUN -> pc=0, IDLE, memory contents preserved.
REQ-034 SHALL cover: NB_MEM_ADDR=2, run from pc=0 without halt -> the fetch index wraps after pc=12, fetching word 0 at pc=16 with o_pcounter4=20.
